// File: rtl/useq_pkg.sv
// Shared encodings, control-word field offsets, opcodes and default microcode
// for the microprogrammed control unit.
package useq_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT  = 2'b00,
    SEQ_DISP1 = 2'b01,
    SEQ_DISP2 = 2'b10,
    SEQ_FETCH = 2'b11
  } seq_t;

  localparam int SEQ_LSB  = 0;
  localparam int WAIT_BIT = 2;
  localparam int CTRL_LSB = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [15:0] ctrl;
    logic        wt;
    seq_t        seq;
  } uword_t;

  localparam uword_t TRAP_WORD = '{ctrl: 16'h0000, wt: 1'b0, seq: SEQ_FETCH};

  function automatic uword_t default_word(input int addr);
    uword_t w;
    case (addr)
      0:       w = '{ctrl: 16'h0851, wt: 1'b1, seq: SEQ_NEXT};
      1:       w = '{ctrl: 16'h1800, wt: 1'b0, seq: SEQ_DISP1};
      2:       w = '{ctrl: 16'h3000, wt: 1'b0, seq: SEQ_DISP2};
      3:       w = '{ctrl: 16'h00C0, wt: 1'b1, seq: SEQ_FETCH};
      4:       w = '{ctrl: 16'h0300, wt: 1'b0, seq: SEQ_FETCH};
      5:       w = '{ctrl: 16'h00A0, wt: 1'b1, seq: SEQ_FETCH};
      6:       w = '{ctrl: 16'hA000, wt: 1'b0, seq: SEQ_NEXT};
      7:       w = '{ctrl: 16'h0500, wt: 1'b0, seq: SEQ_FETCH};
      8:       w = '{ctrl: 16'h6006, wt: 1'b0, seq: SEQ_FETCH};
      9:       w = '{ctrl: 16'h0009, wt: 1'b0, seq: SEQ_FETCH};
      default: w = '{ctrl: 16'h0000, wt: 1'b0, seq: SEQ_NEXT};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/useq_store.sv
// Combinational control store: word {ctrl, wait, seq} at the given micro-address.
module useq_store
  import useq_pkg::*;
#(
  parameter int                 MPC_W     = 4,
  parameter int                 CTRL_W    = 16,
  parameter logic [MPC_W-1:0]   TRAP_ADDR = MPC_W'(4'hF)
) (
  input  logic [MPC_W-1:0]  addr,
  output logic [CTRL_W+2:0] word
);

  uword_t dw;

  // The trap entry overrides whatever microcode would otherwise sit there.
  always_comb begin
    if (addr == TRAP_ADDR) dw = TRAP_WORD;
    else                   dw = default_word(int'(addr));
    word = {CTRL_W'(dw.ctrl), dw.wt, dw.seq};
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: micro-PC, dispatch tables, next-address logic,
// memory-wait stall, illegal-opcode trap and microcycle counter.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int               MPC_W     = 4,
  parameter int               CTRL_W    = 16,
  parameter int               OP_W      = 6,
  parameter logic [MPC_W-1:0] TRAP_ADDR = MPC_W'(4'hF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] control,
  output logic [MPC_W-1:0]  mpc,
  output logic              illegal,
  output logic [15:0]       ucycles
);

  localparam int CW = CTRL_W + 3;

  logic [CW-1:0]    word;
  seq_t             seq;
  logic             wt;
  logic             advance;
  logic             miss;
  logic             d1_hit;
  logic             d2_hit;
  logic [MPC_W-1:0] d1_addr;
  logic [MPC_W-1:0] d2_addr;
  logic [MPC_W-1:0] mpc_next;

  useq_store #(
    .MPC_W     (MPC_W),
    .CTRL_W    (CTRL_W),
    .TRAP_ADDR (TRAP_ADDR)
  ) u_store (
    .addr (mpc),
    .word (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mpc     <= '0;
      illegal <= 1'b0;
      ucycles <= '0;
    end else begin
      illegal <= advance & miss;
      if (advance) begin
        mpc     <= mpc_next;
        ucycles <= ucycles + 16'd1;
      end
    end
  end

  always_comb begin
    d1_hit  = 1'b1;
    d1_addr = '0;
    case (opcode)
      OP_W'(OP_RTYPE):              d1_addr = MPC_W'(6);
      OP_W'(OP_LW), OP_W'(OP_SW):   d1_addr = MPC_W'(2);
      OP_W'(OP_BEQ):                d1_addr = MPC_W'(8);
      OP_W'(OP_J):                  d1_addr = MPC_W'(9);
      default:                      d1_hit  = 1'b0;
    endcase

    d2_hit  = 1'b1;
    d2_addr = '0;
    case (opcode)
      OP_W'(OP_LW): d2_addr = MPC_W'(3);
      OP_W'(OP_SW): d2_addr = MPC_W'(5);
      default:      d2_hit  = 1'b0;
    endcase
  end

  // A waiting word with memory not ready freezes mpc and ucycles.
  always_comb begin
    seq      = seq_t'(word[SEQ_LSB +: 2]);
    wt       = word[WAIT_BIT];
    advance  = !(wt && !mem_ready);
    miss     = 1'b0;
    mpc_next = mpc + MPC_W'(1);
    case (seq)
      SEQ_NEXT:  mpc_next = mpc + MPC_W'(1);
      SEQ_DISP1: begin
        miss     = !d1_hit;
        mpc_next = d1_hit ? d1_addr : TRAP_ADDR;
      end
      SEQ_DISP2: begin
        miss     = !d2_hit;
        mpc_next = d2_hit ? d2_addr : TRAP_ADDR;
      end
      SEQ_FETCH: mpc_next = '0;
    endcase
  end

  always_comb begin
    control = word[CW-1:CTRL_LSB];
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: reset, dispatch paths, stall, trap,
// asynchronous reset and microcycle counter wrap.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic [15:0] control;
  logic [3:0]  mpc;
  logic        illegal;
  logic [15:0] ucycles;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .control   (control),
    .mpc       (mpc),
    .illegal   (illegal),
    .ucycles   (ucycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (mpc !== 4'h0 || control !== 16'h0851 || ucycles !== 16'h0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: mpc=%h control=%h ucycles=%h illegal=%b, required 0 0851 0000 0",
               mpc, control, ucycles, illegal);
    end
  endtask

  task automatic test_lw_path();
    logic [3:0]  em [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
    logic [15:0] ec [5] = '{16'h0851, 16'h1800, 16'h3000, 16'h00C0, 16'h0851};
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (mpc !== em[i] || control !== ec[i]) begin
        errors++;
        $display("FAIL lw_path[%0d]: mpc=%h control=%h, required mpc=%h control=%h",
                 i, mpc, control, em[i], ec[i]);
      end
    end
    checks++;
    if (ucycles !== 16'd4) begin
      errors++;
      $display("FAIL lw_ucycles: got %0d, required 4", ucycles);
    end
  endtask

  task automatic test_stall();
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mpc !== 4'h0 || control !== 16'h0851 || ucycles !== 16'h0) begin
        errors++;
        $display("FAIL stall[%0d]: mpc=%h control=%h ucycles=%h, required 0 0851 0000",
                 i, mpc, control, ucycles);
      end
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (mpc !== 4'h1 || ucycles !== 16'd1) begin
      errors++;
      $display("FAIL stall_release: mpc=%h ucycles=%h, required 1 0001", mpc, ucycles);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] em [5] = '{4'h0, 4'h1, 4'hF, 4'h0, 4'h1};
    logic       ei [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = 6'h3F;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (mpc !== em[i] || illegal !== ei[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: mpc=%h illegal=%b, required mpc=%h illegal=%b",
                 i, mpc, illegal, em[i], ei[i]);
      end
      if (i == 2) begin
        checks++;
        if (control !== 16'h0000) begin
          errors++;
          $display("FAIL trap_control: got %h, required 0000", control);
        end
      end
    end
  endtask

  task automatic test_dispatch();
    logic [5:0]  ops  [4]    = '{6'h04, 6'h00, 6'h2B, 6'h02};
    int          lens [4]    = '{4, 5, 5, 4};
    logic [3:0]  em   [4][5] = '{'{4'h0, 4'h1, 4'h8, 4'h0, 4'h0},
                                 '{4'h0, 4'h1, 4'h6, 4'h7, 4'h0},
                                 '{4'h0, 4'h1, 4'h2, 4'h5, 4'h0},
                                 '{4'h0, 4'h1, 4'h9, 4'h0, 4'h0}};
    logic [15:0] ec   [4][5] = '{'{16'h0851, 16'h1800, 16'h6006, 16'h0851, 16'h0},
                                 '{16'h0851, 16'h1800, 16'hA000, 16'h0500, 16'h0851},
                                 '{16'h0851, 16'h1800, 16'h3000, 16'h00A0, 16'h0851},
                                 '{16'h0851, 16'h1800, 16'h0009, 16'h0851, 16'h0}};
    for (int p = 0; p < 4; p++) begin
      do_reset();
      opcode = ops[p];
      mem_ready = 1'b1;
      for (int i = 0; i < lens[p]; i++) begin
        if (i > 0) step();
        checks++;
        if (mpc !== em[p][i] || control !== ec[p][i] || illegal !== 1'b0) begin
          errors++;
          $display("FAIL dispatch op=%h step %0d: mpc=%h control=%h illegal=%b, required mpc=%h control=%h illegal=0",
                   ops[p], i, mpc, control, illegal, em[p][i], ec[p][i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (mpc !== 4'h3 || ucycles !== 16'd3) begin
      errors++;
      $display("FAIL stall_at_3: mpc=%h ucycles=%h, required 3 0003", mpc, ucycles);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (mpc !== 4'h0 || ucycles !== 16'h0 || illegal !== 1'b0 || control !== 16'h0851) begin
      errors++;
      $display("FAIL async_reset: mpc=%h ucycles=%h illegal=%b control=%h, required 0 0000 0 0851",
               mpc, ucycles, illegal, control);
    end
    step();
    rst = 1'b0;
    opcode = 6'h3F;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (illegal !== 1'b1 || mpc !== 4'hF) begin
      errors++;
      $display("FAIL pre_reset_trap: mpc=%h illegal=%b, required F 1", mpc, illegal);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b0 || mpc !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_illegal: mpc=%h illegal=%b, required 0 0", mpc, illegal);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_ucycles_wrap();
    logic [3:0] lw_seq [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
    int n = 0;
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b1;
    while (ucycles !== 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    checks++;
    if (n != 65535) begin
      errors++;
      $display("FAIL wrap_reach: reached ucycles=%h after %0d advances, required FFFF after 65535",
               ucycles, n);
    end
    checks++;
    if (mpc !== lw_seq[n % 4]) begin
      errors++;
      $display("FAIL wrap_mpc_before: mpc=%h, required %h", mpc, lw_seq[n % 4]);
    end
    step();
    n++;
    checks++;
    if (ucycles !== 16'h0 || mpc !== lw_seq[n % 4]) begin
      errors++;
      $display("FAIL wrap: ucycles=%h mpc=%h, required 0000 %h", ucycles, mpc, lw_seq[n % 4]);
    end
    step();
    n++;
    checks++;
    if (ucycles !== 16'h1 || mpc !== lw_seq[n % 4]) begin
      errors++;
      $display("FAIL after_wrap: ucycles=%h mpc=%h, required 0001 %h", ucycles, mpc, lw_seq[n % 4]);
    end
  endtask

  initial begin
    test_reset();
    test_lw_path();
    test_stall();
    test_illegal();
    test_dispatch();
    test_async_reset();
    test_ucycles_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
